// File: rtl/alu_muldiv_seq_if.sv
// rtl/alu_muldiv_seq_if.sv - request/result and shared-ALU signals of the MULTU/DIVU sequencer
// The divzero flag exists only when MULDIV_DIVZERO_EN is defined.
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] alu_srca;
  logic [WIDTH-1:0] alu_srcb;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] alu_out;
`ifdef MULDIV_DIVZERO_EN
  logic             divzero;

  modport master (
    output start, op, a, b, alu_out,
    input  busy, done, hi, lo, alu_srca, alu_srcb, alu_control, divzero
  );

  modport slave (
    input  start, op, a, b, alu_out,
    output busy, done, hi, lo, alu_srca, alu_srcb, alu_control, divzero
  );
`else
  modport master (
    output start, op, a, b, alu_out,
    input  busy, done, hi, lo, alu_srca, alu_srcb, alu_control
  );

  modport slave (
    input  start, op, a, b, alu_out,
    output busy, done, hi, lo, alu_srca, alu_srcb, alu_control
  );
`endif
endinterface

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - iterative unsigned MULTU/DIVU built on the shared ALU (ADD/SUB/SLT only)
// MULDIV_DIVZERO_EN adds a divzero flag and a one-cycle shortcut for DIVU by zero.
module alu_muldiv_seq #(
  parameter int         WIDTH  = 32,
  parameter logic [2:0] AC_ADD = 3'b010,
  parameter logic [2:0] AC_SUB = 3'b110,
  parameter logic [2:0] AC_SLT = 3'b111
) (
  input  logic              clk,
  input  logic              reset,
  alu_muldiv_seq_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, PH_A, PH_B, DONE} state_t;

  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;     // multiplicand or divisor
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] tmp_q, tmp_d;       // partial sum (MULTU) or shifted remainder r (DIVU)
  logic [WIDTH-1:0] addend_q, addend_d;
  logic             m_q, m_d;
  logic             lt_q, lt_d;
`ifdef MULDIV_DIVZERO_EN
  logic             divzero_q, divzero_d;
`endif

  logic [WIDTH-1:0] srca, srcb;
  logic [2:0]       ctrl;
  logic [WIDTH-1:0] div_r;
  logic             div_q;

  assign div_r = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  // A set overflow bit means r already exceeds any divisor, so subtract regardless of SLT.
  assign div_q = m_q | ~lt_q;

  always_comb begin : alu_drive
    srca = '0;
    srcb = '0;
    ctrl = AC_ADD;
    case (state_q)
      PH_A: begin
        if (!op_q) begin
          ctrl = AC_ADD;
          srca = hi_q;
          srcb = lo_q[0] ? opnd_q : '0;
        end else begin
          ctrl = AC_SLT;
          srca = div_r;
          srcb = opnd_q;
        end
      end
      PH_B: begin
        if (!op_q) begin
          // sum < addend exposes the carry out of the previous ADD
          ctrl = AC_SLT;
          srca = tmp_q;
          srcb = addend_q;
        end else begin
          ctrl = AC_SUB;
          srca = tmp_q;
          srcb = div_q ? opnd_q : '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin : next_state
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_d    = tmp_q;
    addend_d = addend_q;
    m_d      = m_q;
    lt_d     = lt_q;
`ifdef MULDIV_DIVZERO_EN
    divzero_d = divzero_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          cnt_d   = '0;
          hi_d    = '0;
          opnd_d  = bus.op ? bus.b : bus.a;
          lo_d    = bus.op ? bus.a : bus.b;
          state_d = PH_A;
`ifdef MULDIV_DIVZERO_EN
          divzero_d = 1'b0;
          if (bus.op && (bus.b == '0)) begin
            lo_d      = '1;
            hi_d      = bus.a;
            divzero_d = 1'b1;
            state_d   = DONE;
          end
`endif
        end
      end
      PH_A: begin
        if (!op_q) begin
          tmp_d    = bus.alu_out;
          addend_d = srcb;
        end else begin
          tmp_d = div_r;
          m_d   = hi_q[WIDTH-1];
          lt_d  = bus.alu_out[0];
          lo_d  = lo_q << 1;
        end
        state_d = PH_B;
      end
      PH_B: begin
        if (!op_q) begin
          hi_d = {bus.alu_out[0], tmp_q[WIDTH-1:1]};
          lo_d = {tmp_q[0], lo_q[WIDTH-1:1]};
        end else begin
          hi_d = bus.alu_out;
          lo_d = {lo_q[WIDTH-1:1], div_q};
        end
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = PH_A;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= 1'b0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      tmp_q    <= '0;
      addend_q <= '0;
      m_q      <= 1'b0;
      lt_q     <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
      divzero_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_q    <= tmp_d;
      addend_q <= addend_d;
      m_q      <= m_d;
      lt_q     <= lt_d;
`ifdef MULDIV_DIVZERO_EN
      divzero_q <= divzero_d;
`endif
    end
  end

  assign bus.busy        = (state_q == PH_A) || (state_q == PH_B);
  assign bus.done        = (state_q == DONE);
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.alu_srca    = srca;
  assign bus.alu_srcb    = srcb;
  assign bus.alu_control = ctrl;
`ifdef MULDIV_DIVZERO_EN
  assign bus.divzero     = divzero_q;
`endif

endmodule
